// File: rtl/tb_wait_event.sv
// Wait-for-event stage: after a start request, counts clock cycles until a selected
// edge/level appears on evt_in or a programmable timeout expires.
//
// state  | meaning
// S_IDLE | no wait pending; start is accepted here
// S_WAIT | counting cycles, watching evt_in for the latched event type
module tb_wait_event #(
  parameter int G_CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [G_CNT_WIDTH-1:0] timeout_val,
  input  logic [1:0]             evt_sel,
  input  logic                   evt_in,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [G_CNT_WIDTH-1:0] elapsed
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_RISE = 2'd0;
  localparam logic [1:0] SEL_FALL = 2'd1;
  localparam logic [1:0] SEL_HIGH = 2'd2;
  localparam logic [1:0] SEL_LOW  = 2'd3;

  localparam logic [G_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [G_CNT_WIDTH-1:0] CNT_ONE = G_CNT_WIDTH'(1);

  state_t                   state;
  logic                     evt_q;
  logic [G_CNT_WIDTH-1:0]   cnt;
  logic [G_CNT_WIDTH-1:0]   tmo_q;
  logic [1:0]               sel_q;
  logic                     evt_hit;
  logic                     tmo_hit;

  always_comb begin
    evt_hit = 1'b0;
    unique case (sel_q)
      SEL_RISE: evt_hit = evt_in & ~evt_q;
      SEL_FALL: evt_hit = ~evt_in & evt_q;
      SEL_HIGH: evt_hit = evt_in;
      SEL_LOW:  evt_hit = ~evt_in;
      default:  evt_hit = 1'b0;
    endcase
  end

  // A zero timeout disables expiry entirely; the wait then runs until the event.
  assign tmo_hit = (tmo_q != '0) && (cnt == (tmo_q - CNT_ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      evt_q   <= 1'b0;
      cnt     <= '0;
      tmo_q   <= '0;
      sel_q   <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      elapsed <= '0;
    end else begin
      evt_q   <= evt_in;
      done    <= 1'b0;
      timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            tmo_q   <= timeout_val;
            sel_q   <= evt_sel;
            cnt     <= '0;
            elapsed <= '0;
            busy    <= 1'b1;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Event takes priority over a simultaneous timeout expiry.
          if (evt_hit) begin
            done    <= 1'b1;
            elapsed <= cnt;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (tmo_hit) begin
            timeout <= 1'b1;
            elapsed <= cnt;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
